// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
// Purpose : AXI3-style bus bundle between a cache initiator and the
//           axi_sram_slave memory responder. Clock and reset are not
//           carried here; they stay plain ports on the modules.
// Modports: master - drives AW/W/AR payload + valids, B/R readies
//           slave  - drives AW/W/AR readies, B/R payload + valids
// ---------------------------------------------------------------------------
interface axi_sram_slave_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// Purpose : AXI3-style slave backed by a 2^MEM_AW x 32-bit word array.
//           Serves INCR/FIXED bursts up to 16 beats (cache line fills and
//           write-backs) and single-beat uncached accesses with strobes.
//           Read and write channels are independent, one outstanding
//           transaction per direction. WRAP/reserved bursts get SLVERR.
// Ports   : aclk    - clock
//           aresetn - asynchronous active-low reset (array not cleared)
//           bus     - axi_sram_slave_if.slave (AW, W, B, AR, R channels)
// Config  : `define AXI_SLV_BACKPRESSURE_EN to add LFSR-driven random
//           ready/valid throttling (seeded by LFSR_SEED).
// ---------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int          MEM_AW    = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            aclk,
  input  logic            aresetn,
  axi_sram_slave_if.slave bus
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Next beat address: INCR advances by the beat size, everything else holds.
  function automatic logic [31:0] next_addr(input logic [31:0] a,
                                            input logic [2:0]  sz,
                                            input logic [1:0]  bu);
    if (bu == 2'b01) next_addr = a + (32'd1 << sz);
    else             next_addr = a;
  endfunction

  // Byte-lane merge of new data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    for (int i = 0; i < 4; i++)
      merge_bytes[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
  endfunction

  logic [31:0] mem_r [0:(1<<MEM_AW)-1];

  w_state_e    w_state_r, w_next_s;
  r_state_e    r_state_r, r_next_s;

  logic [31:0] waddr_r;
  logic [3:0]  wlen_r, wcnt_r, bid_r;
  logic [2:0]  wsize_r;
  logic [1:0]  wburst_r, bresp_r;
  logic        werr_r, wdone_r, bvalid_r;

  logic [31:0] raddr_r, rdata_r;
  logic [3:0]  rlen_r, rcnt_r, rid_r;
  logic [2:0]  rsize_r;
  logic [1:0]  rburst_r, rresp_r;
  logic        rerr_r, rlast_r, rvalid_r, rpend_r;

  logic        awready_s, wready_s, arready_s;
  logic        aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, rload_s, mem_we_s;
  logic        bp_aw_s, bp_w_s, bp_ar_s, bp_r_s, bp_b_s;
  logic        unused_s;

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr_r;

  // Fibonacci LFSR, taps 16,14,13,11, free-running throttle source.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_r <= LFSR_SEED;
    else          lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  end

  assign bp_aw_s  = lfsr_r[0];
  assign bp_w_s   = lfsr_r[1];
  assign bp_ar_s  = lfsr_r[2];
  assign bp_r_s   = lfsr_r[3];
  assign bp_b_s   = lfsr_r[4];
  assign unused_s = ^bus.wid;
`else
  assign bp_aw_s  = 1'b1;
  assign bp_w_s   = 1'b1;
  assign bp_ar_s  = 1'b1;
  assign bp_r_s   = 1'b1;
  assign bp_b_s   = 1'b1;
  assign unused_s = ^{bus.wid, LFSR_SEED};
`endif

  assign aw_hs_s  = bus.awvalid & awready_s;
  assign w_hs_s   = bus.wvalid  & wready_s;
  assign b_hs_s   = bvalid_r    & bus.bready;
  assign ar_hs_s  = bus.arvalid & arready_s;
  assign r_hs_s   = rvalid_r    & bus.rready;
  assign mem_we_s = w_hs_s & ~werr_r;
  // Next read beat is fetched after a non-last handshake, or later if held off.
  assign rload_s  = (r_state_r == R_DATA) & bp_r_s & ((r_hs_s & ~rlast_r) | rpend_r);

  // FSM state registers for both channels.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_r <= W_IDLE;
      r_state_r <= R_IDLE;
    end else begin
      w_state_r <= w_next_s;
      r_state_r <= r_next_s;
    end
  end

  // Write FSM next state and ready decode.
  always_comb begin
    w_next_s  = w_state_r;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        awready_s = bp_aw_s;
        if (aw_hs_s) w_next_s = W_DATA;
        else         w_next_s = W_IDLE;
      end
      W_DATA: begin
        wready_s = bp_w_s;
        if (w_hs_s && bus.wlast) w_next_s = W_RESP;
        else                     w_next_s = W_DATA;
      end
      W_RESP: begin
        if (b_hs_s) w_next_s = W_IDLE;
        else        w_next_s = W_RESP;
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Read FSM next state and ready decode.
  always_comb begin
    r_next_s  = r_state_r;
    arready_s = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        arready_s = bp_ar_s;
        if (ar_hs_s) r_next_s = R_DATA;
        else         r_next_s = R_IDLE;
      end
      R_DATA: begin
        if (r_hs_s && rlast_r) r_next_s = R_IDLE;
        else                   r_next_s = R_DATA;
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Write channel datapath: command latch, beat count, B response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      waddr_r  <= 32'd0;
      wlen_r   <= 4'd0;
      wsize_r  <= 3'd0;
      wburst_r <= 2'd0;
      werr_r   <= 1'b0;
      wcnt_r   <= 4'd0;
      wdone_r  <= 1'b0;
      bid_r    <= 4'd0;
      bresp_r  <= 2'd0;
      bvalid_r <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            bid_r    <= bus.awid;
            waddr_r  <= bus.awaddr;
            wlen_r   <= bus.awlen;
            wsize_r  <= bus.awsize;
            wburst_r <= bus.awburst;
            werr_r   <= bus.awburst[1];
            wcnt_r   <= 4'd0;
            wdone_r  <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            waddr_r <= next_addr(waddr_r, wsize_r, wburst_r);
            wcnt_r  <= wcnt_r + 4'd1;
            // done marks that 16 beats were taken, so a 17th+ never aliases.
            wdone_r <= wdone_r | (wcnt_r == 4'hF);
            if (bus.wlast) begin
              bresp_r  <= (werr_r || wdone_r || (wcnt_r != wlen_r)) ? 2'b10 : 2'b00;
              bvalid_r <= bp_b_s;
            end
          end
        end
        W_RESP: begin
          if (b_hs_s)         bvalid_r <= 1'b0;
          else if (!bvalid_r) bvalid_r <= bp_b_s;
        end
        default: bvalid_r <= 1'b0;
      endcase
    end
  end

  // Array write port; no reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (mem_we_s)
      mem_r[waddr_r[MEM_AW+1:2]] <= merge_bytes(mem_r[waddr_r[MEM_AW+1:2]], bus.wdata, bus.wstrb);
  end

  // Read channel datapath: command latch and beat presentation.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      raddr_r  <= 32'd0;
      rlen_r   <= 4'd0;
      rsize_r  <= 3'd0;
      rburst_r <= 2'd0;
      rerr_r   <= 1'b0;
      rcnt_r   <= 4'd0;
      rid_r    <= 4'd0;
      rdata_r  <= 32'd0;
      rresp_r  <= 2'd0;
      rlast_r  <= 1'b0;
      rvalid_r <= 1'b0;
      rpend_r  <= 1'b0;
    end else if (r_state_r == R_IDLE) begin
      if (ar_hs_s) begin
        rid_r    <= bus.arid;
        rlen_r   <= bus.arlen;
        rsize_r  <= bus.arsize;
        rburst_r <= bus.arburst;
        rerr_r   <= bus.arburst[1];
        raddr_r  <= next_addr(bus.araddr, bus.arsize, bus.arburst);
        rcnt_r   <= 4'd0;
        rdata_r  <= bus.arburst[1] ? 32'd0 : mem_r[bus.araddr[MEM_AW+1:2]];
        rresp_r  <= bus.arburst[1] ? 2'b10 : 2'b00;
        rlast_r  <= (bus.arlen == 4'd0);
        rvalid_r <= 1'b1;
        rpend_r  <= 1'b0;
      end
    end else begin
      if (rload_s) begin
        rdata_r  <= rerr_r ? 32'd0 : mem_r[raddr_r[MEM_AW+1:2]];
        raddr_r  <= next_addr(raddr_r, rsize_r, rburst_r);
        rcnt_r   <= rcnt_r + 4'd1;
        rlast_r  <= ((rcnt_r + 4'd1) == rlen_r);
        rvalid_r <= 1'b1;
        rpend_r  <= 1'b0;
      end else if (r_hs_s) begin
        rvalid_r <= 1'b0;
        if (rlast_r) rlast_r <= 1'b0;
        else         rpend_r <= 1'b1;
      end
    end
  end

  assign bus.awready = awready_s;
  assign bus.wready  = wready_s;
  assign bus.arready = arready_s;
  assign bus.bid     = bid_r;
  assign bus.bresp   = bresp_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.rid     = rid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.rlast   = rlast_r;
  assign bus.rvalid  = rvalid_r;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Purpose : directed self-checking bench for axi_sram_slave (default build):
//           line write-back/fill, uncached byte store, read backpressure,
//           error bursts and reset in the middle of bursts.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axi_sram_slave_if bus_if();

  axi_sram_slave #(.MEM_AW(10), .LFSR_SEED(16'hACE1)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus_if)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] wbuf    [16];
  logic [31:0] rbuf    [16];
  logic        rlast_q [16];
  logic [1:0]  rresp_q [16];
  logic [3:0]  rid_q   [16];
  int          rcount;
  int          rcycles;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_id;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check_val({pfx, "_awready"}, bus_if.awready, 32'd1);
    check_val({pfx, "_arready"}, bus_if.arready, 32'd1);
    check_val({pfx, "_wready"},  bus_if.wready,  32'd0);
    check_val({pfx, "_bvalid"},  bus_if.bvalid,  32'd0);
    check_val({pfx, "_rvalid"},  bus_if.rvalid,  32'd0);
    check_val({pfx, "_rlast"},   bus_if.rlast,   32'd0);
    check_val({pfx, "_rdata"},   bus_if.rdata,   32'd0);
    check_val({pfx, "_bresp"},   bus_if.bresp,   32'd0);
    check_val({pfx, "_rresp"},   bus_if.rresp,   32'd0);
    check_val({pfx, "_bid"},     bus_if.bid,     32'd0);
    check_val({pfx, "_rid"},     bus_if.rid,     32'd0);
  endtask

  // One write transaction; finish_b=0 leaves the burst open (no wlast, no B).
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input int nbeats, input bit finish_b,
                          output logic [1:0] resp, output logic [3:0] rsp_id);
    bus_if.awid    = id;
    bus_if.awaddr  = addr;
    bus_if.awlen   = len;
    bus_if.awsize  = size;
    bus_if.awburst = burst;
    bus_if.awvalid = 1'b1;
    for (int k = 0; k < 50 && bus_if.awready !== 1'b1; k++) tick();
    check_val("awready", bus_if.awready, 32'd1);
    tick();
    bus_if.awvalid = 1'b0;
    check_val("wready_lat", bus_if.wready, 32'd1);
    for (int i = 0; i < nbeats; i++) begin
      bus_if.wdata  = wbuf[i];
      bus_if.wstrb  = strb;
      bus_if.wlast  = finish_b && (i == nbeats - 1);
      bus_if.wvalid = 1'b1;
      for (int k = 0; k < 50 && bus_if.wready !== 1'b1; k++) tick();
      tick();
    end
    bus_if.wvalid = 1'b0;
    bus_if.wlast  = 1'b0;
    resp   = 2'b11;
    rsp_id = 4'hF;
    if (finish_b) begin
      check_val("bvalid_lat", bus_if.bvalid, 32'd1);
      bus_if.bready = 1'b1;
      for (int k = 0; k < 50 && bus_if.bvalid !== 1'b1; k++) tick();
      resp   = bus_if.bresp;
      rsp_id = bus_if.bid;
      tick();
      bus_if.bready = 1'b0;
      check_val("bvalid_clr", bus_if.bvalid, 32'd0);
    end
  endtask

  // One read transaction; stall_pat drives rready 1,0,0,1,0,0...; stops after maxb beats.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input bit stall_pat, input int maxb);
    logic        got_last, prev_stall, pl;
    logic [31:0] pd;
    bus_if.arid    = id;
    bus_if.araddr  = addr;
    bus_if.arlen   = len;
    bus_if.arsize  = 3'd2;
    bus_if.arburst = burst;
    bus_if.arvalid = 1'b1;
    for (int k = 0; k < 50 && bus_if.arready !== 1'b1; k++) tick();
    check_val("arready", bus_if.arready, 32'd1);
    tick();
    bus_if.arvalid = 1'b0;
    check_val("rvalid_lat", bus_if.rvalid, 32'd1);
    rcount     = 0;
    rcycles    = 0;
    got_last   = 1'b0;
    prev_stall = 1'b0;
    pd         = 32'd0;
    pl         = 1'b0;
    while (!got_last && rcount < maxb && rcount < 16 && rcycles < 200) begin
      bus_if.rready = stall_pat ? ((rcycles % 3) == 0) : 1'b1;
      if (prev_stall) begin
        check_val("r_hold_valid", bus_if.rvalid, 32'd1);
        check_val("r_hold_data",  bus_if.rdata,  pd);
        check_val("r_hold_last",  bus_if.rlast,  {31'd0, pl});
      end
      prev_stall = (bus_if.rvalid === 1'b1) && !bus_if.rready;
      pd = bus_if.rdata;
      pl = bus_if.rlast;
      if (bus_if.rvalid === 1'b1 && bus_if.rready) begin
        rbuf[rcount]    = bus_if.rdata;
        rlast_q[rcount] = bus_if.rlast;
        rresp_q[rcount] = bus_if.rresp;
        rid_q[rcount]   = bus_if.rid;
        got_last        = bus_if.rlast;
        rcount++;
      end
      tick();
      rcycles++;
    end
    bus_if.rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.awid = 4'd0; bus_if.awaddr = 32'd0; bus_if.awlen = 4'd0; bus_if.awsize = 3'd0;
    bus_if.awburst = 2'd0; bus_if.awvalid = 1'b0;
    bus_if.wid = 4'd0; bus_if.wdata = 32'd0; bus_if.wstrb = 4'd0; bus_if.wlast = 1'b0;
    bus_if.wvalid = 1'b0; bus_if.bready = 1'b0;
    bus_if.arid = 4'd0; bus_if.araddr = 32'd0; bus_if.arlen = 4'd0; bus_if.arsize = 3'd0;
    bus_if.arburst = 2'd0; bus_if.arvalid = 1'b0; bus_if.rready = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    check_reset("rst");
    aresetn = 1'b1;
    tick();

    // Cached write-back: 8 beats 0x11..0x88 at 0x100
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h11 * (i + 1);
    do_write(4'h5, 32'h100, 4'd7, 3'd2, 2'b01, 4'hF, 8, 1'b1, wr_resp, wr_id);
    check_val("wb_bresp", wr_resp, 32'd0);
    check_val("wb_bid",   wr_id,   32'h5);

    // Line fill, rready held high: 8 back-to-back beats
    do_read(4'h9, 32'h100, 4'd7, 2'b01, 1'b0, 16);
    check_val("fill_beats",  rcount,  32'd8);
    check_val("fill_cycles", rcycles, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("fill_data", rbuf[i],    32'h11 * (i + 1));
      check_val("fill_last", rlast_q[i], (i == 7) ? 32'd1 : 32'd0);
      check_val("fill_rid",  rid_q[i],   32'h9);
      check_val("fill_resp", rresp_q[i], 32'd0);
    end
    check_val("fill_rvalid_end", bus_if.rvalid, 32'd0);

    // Uncached byte store into 0xAABBCCDD at 0x204
    wbuf[0] = 32'hAABBCCDD;
    do_write(4'h1, 32'h204, 4'd0, 3'd2, 2'b01, 4'hF, 1, 1'b1, wr_resp, wr_id);
    check_val("init_bresp", wr_resp, 32'd0);
    wbuf[0] = 32'h0000EE00;
    do_write(4'h2, 32'h205, 4'd0, 3'd0, 2'b01, 4'b0010, 1, 1'b1, wr_resp, wr_id);
    check_val("byte_bresp", wr_resp, 32'd0);
    do_read(4'h3, 32'h204, 4'd0, 2'b01, 1'b0, 16);
    check_val("byte_data", rbuf[0],    32'hAABBEEDD);
    check_val("byte_last", rlast_q[0], 32'd1);

    // Read backpressure: rready 1,0,0 pattern
    do_read(4'h4, 32'h100, 4'd7, 2'b01, 1'b1, 16);
    check_val("bp_beats", rcount, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("bp_data", rbuf[i],    32'h11 * (i + 1));
      check_val("bp_last", rlast_q[i], (i == 7) ? 32'd1 : 32'd0);
    end

    // WRAP write: no array change, SLVERR
    wbuf[0] = 32'hDEADBEEF;
    do_write(4'h6, 32'h100, 4'd0, 3'd2, 2'b10, 4'hF, 1, 1'b1, wr_resp, wr_id);
    check_val("wrap_bresp", wr_resp, 32'd2);
    check_val("wrap_bid",   wr_id,   32'h6);
    do_read(4'h0, 32'h100, 4'd0, 2'b01, 1'b0, 16);
    check_val("wrap_nochange", rbuf[0], 32'h11);

    // Short burst: awlen 3 but wlast on beat 2
    wbuf[0] = 32'h10000001;
    wbuf[1] = 32'h10000002;
    do_write(4'h7, 32'h300, 4'd3, 3'd2, 2'b01, 4'hF, 2, 1'b1, wr_resp, wr_id);
    check_val("short_bresp", wr_resp, 32'd2);
    do_read(4'h0, 32'h300, 4'd1, 2'b01, 1'b0, 16);
    check_val("short_w0", rbuf[0], 32'h10000001);
    check_val("short_w1", rbuf[1], 32'h10000002);

    // Reserved read burst: SLVERR and zero data on each beat
    do_read(4'h8, 32'h100, 4'd3, 2'b11, 1'b0, 16);
    check_val("rsv_beats", rcount, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("rsv_resp", rresp_q[i], 32'd2);
      check_val("rsv_data", rbuf[i],    32'd0);
      check_val("rsv_last", rlast_q[i], (i == 3) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a read (3 beats) and a write (2 beats)
    do_read(4'hA, 32'h100, 4'd7, 2'b01, 1'b0, 3);
    check_val("mid_rbeats", rcount, 32'd3);
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h5500 + i;
    do_write(4'hB, 32'h500, 4'd7, 3'd2, 2'b01, 4'hF, 2, 1'b0, wr_resp, wr_id);
    aresetn = 1'b0;
    #1;
    check_reset("async");
    tick();
    check_reset("mid");
    aresetn = 1'b1;
    tick();
    do_read(4'hC, 32'h100, 4'd7, 2'b01, 1'b0, 16);
    check_val("post_beats", rcount, 32'd8);
    for (int i = 0; i < 8; i++)
      check_val("post_data", rbuf[i], 32'h11 * (i + 1));
    do_read(4'hD, 32'h500, 4'd1, 2'b01, 1'b0, 16);
    check_val("mid_w0", rbuf[0], 32'h5500);
    check_val("mid_w1", rbuf[1], 32'h5501);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3-style slave responder backed by a word-addressed register array. It is the memory end of the link driven by the dcache/icache AXI initiators. It serves cached 8-beat INCR line fills and write-backs, and single-beat uncached accesses with size and strobe. It is used as the simulation memory and the on-chip scratch RAM. Read and write channels run independently, with one outstanding transaction per direction.

Parameters:
MEM_AW, 10, word-index width; depth is 2^MEM_AW words of 32 bits.
LFSR_SEED, 16'hACE1, seed for the backpressure LFSR (used only with AXI_SLV_BACKPRESSURE_EN).

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
awid  in  4  write ID
awaddr  in  32  write start byte address
awlen  in  4  beats minus 1
awsize  in  3  bytes per beat, log2
awburst  in  2  burst type
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  ignored
wdata  in  32  write data
wstrb  in  4  byte lane enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  response ID
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  4  read ID
araddr  in  32  read start byte address
arlen  in  4  beats minus 1
arsize  in  3  bytes per beat, log2
arburst  in  2  burst type
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  4  read ID
rdata  out  32  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready

Behaviour:
- Reset values:
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - rdata=0, bresp=0, rresp=0, bid=0, rid=0.
  - Reset returns both FSMs to idle and drops the beat counters. Array contents are not cleared.
  - A burst interrupted by reset is abandoned. Beats already written stay written.
- Word index is addr[MEM_AW+1:2]. Higher address bits are ignored (aliasing). addr[1:0] is ignored.
- Address step after each beat:
  - INCR (01): add 1<<size, truncated to 32 bits.
  - FIXED (00): no change.
  - WRAP (10) or reserved (11): transaction is flagged as an error.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. An AW handshake latches id, addr, len, size, burst and err. Next state is W_DATA.
  - W_DATA: wready=1, awready=0.
    - Each W handshake writes the array word byte-wise per wstrb. No write happens if err is set.
    - Each handshake increments the beat counter.
    - The W handshake with wlast=1 moves to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. bresp=2'b10 (SLVERR) if err is set or beat count != len+1; otherwise 2'b00. bvalid holds until bready, then the FSM returns to W_IDLE.
- Write latency:
  - AW handshake at cycle N gives wready at N+1.
  - Last W handshake at cycle M gives bvalid at M+1.
  - W before AW is not accepted, since wready=0 until AW is taken.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. An AR handshake at cycle N latches id, len, size, burst and err. It loads rdata=mem[araddr], sets rvalid=1 and sets rlast=(arlen==0) at N+1.
  - R_DATA:
    - rvalid, rdata and rlast hold stable while rready=0.
    - A handshake on a non-last beat loads the next beat in the same edge, so back-to-back beats come at one per cycle.
    - A handshake on the last beat clears rvalid and rlast, and the FSM returns to R_IDLE.
    - rresp is SLVERR on every beat when err is set, with rdata=0.
    - arready=0 throughout.
- The read always returns the full 32-bit word regardless of arsize.
- Same-edge read load and write to one word: the read gets the pre-write data.
- awlen and arlen of 15 give 16 beats. The beat counter is 4 bits plus a done flag, with no wrap ambiguity.

Optional Feature:
AXI_SLV_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED on reset, advances every cycle.
  - awready, wready and arready are additionally ANDed with LFSR bits 0, 1 and 2.
  - In R_DATA, presentation of the next beat is held off while bit 3 is 0; rvalid stays 0 for that cycle.
  - bvalid assertion is delayed while bit 4 is 0.
  - Handshake rules are unchanged.
- Undefined: the LFSR is absent, and readies and valids follow the FSM decode above with zero added delay.

Test Plan:
- Cached write-back: AW addr 0x100, len 7, size 2, INCR; W data 0x11..0x88 with wstrb F and wlast on beat 8 -> words 0x40..0x47 hold 0x11..0x88; bvalid the cycle after the last beat; bresp 00; bid = awid.
- Line fill: AR addr 0x100, len 7 with rready=1 -> rvalid the cycle after AR, 8 consecutive beats 0x11..0x88, rlast only on beat 8, rid = arid.
- Uncached byte store: memory 0xAABBCCDD at 0x204; AW len 0, size 0; W wdata 0x0000EE00, wstrb 0010 -> word reads 0xAABBEEDD.
- Read backpressure: rready toggles 1,0,0,1... during an 8-beat read -> rdata and rlast are stable while rready=0; no beat is lost or duplicated.
- Errors:
  - awburst 10 -> no array change, bresp 10.
  - awlen 3 with wlast on beat 2 -> bresp 10, beats 1-2 written.
  - arburst 11 -> rresp 10 on every beat.
- Reset mid-burst: assert aresetn=0 after read beat 3 and write beat 2 -> all outputs at reset values next cycle; the next AR at 0x100 returns the intact array data.
